// File: rtl/text_ram_pkg.sv
// Shared widths, grant encoding and RAM command payload for the text RAM arbiter.
// Also holds the clear-sequencer state type.
package text_ram_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_DISP,
    GNT_CLR,
    GNT_HOST
  } gnt_e;

  typedef enum logic [1:0] {
    CLR_IDLE,
    CLR_FILL,
    CLR_DONE
  } clr_state_e;

  // One RAM cycle as driven by whichever requester holds the grant.
  typedef struct packed {
    logic  we;
    addr_t addr;
    data_t din;
  } ram_cmd_t;

endpackage

// File: rtl/text_ram_arbiter_if.sv
// Host read/write port of the text RAM arbiter.
// The host holds host_req until it sees the one-cycle host_ack.
interface text_ram_arbiter_if;
  import text_ram_pkg::*;

  logic  host_req;
  logic  host_we;
  addr_t host_addr;
  data_t host_wdata;
  logic  host_ack;
  data_t host_rdata;

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_ack, host_rdata
  );

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_ack, host_rdata
  );

endinterface

// File: rtl/text_ram_arbiter_clear_sequencer.sv
// Screen-clear sequencer: writes a latched byte to every RAM address in order,
// holding its position on cycles where it does not own the RAM.
module clear_sequencer
  import text_ram_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  start,
  input  data_t value,
  input  logic  stall,
  output logic  busy,
  output logic  done,
  output logic  start_ok_c,
  output addr_t fill_addr,
  output data_t fill_data
);

  clr_state_e state_q, state_d;
  addr_t      cnt_q, cnt_d;
  data_t      val_q, val_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CLR_IDLE;
      cnt_q   <= '0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
    end
  end

  // A start while filling is dropped: no restart and no relatch of the value.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    val_d      = val_q;
    start_ok_c = 1'b0;
    case (state_q)
      CLR_IDLE, CLR_DONE: begin
        state_d = CLR_IDLE;
        if (start) begin
          start_ok_c = 1'b1;
          state_d    = CLR_FILL;
          cnt_d      = '0;
          val_d      = value;
        end
      end
      CLR_FILL: begin
        if (!stall) begin
          cnt_d = cnt_q + ADDR_W'(1);
          if (cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_d = CLR_DONE;
          end
        end
      end
      default: state_d = CLR_IDLE;
    endcase
  end

  assign busy      = (state_q == CLR_FILL);
  assign done      = (state_q == CLR_DONE);
  assign fill_addr = cnt_q;
  assign fill_data = val_q;

endmodule

// File: rtl/text_ram_arbiter.sv
// Fixed-priority arbiter for the single-port text RAM: display fetch, then
// screen clear, then host. Display fetches are never delayed.
module text_ram_arbiter
  import text_ram_pkg::*;
(
  input  logic  clk,
  input  logic  reset,

  input  logic  disp_req,
  input  addr_t disp_addr,
  output data_t disp_data,
  output logic  disp_valid,

  text_ram_arbiter_if.slave host,

  input  logic  clr_start,
  input  data_t clr_value,
  output logic  clr_busy,
  output logic  clr_done,

  output addr_t ram_addr,
  output data_t ram_din,
  output logic  ram_we,
  input  data_t ram_dout
);

  gnt_e     gnt_c;
  ram_cmd_t cmd_c;
  logic     host_ok_c;
  logic     clr_start_ok_c;
  addr_t    fill_addr;
  data_t    fill_data;
  logic     disp_valid_q;
  logic     host_ack_q;

  clear_sequencer u_clear_sequencer (
    .clk        (clk),
    .reset      (reset),
    .start      (clr_start),
    .value      (clr_value),
    .stall      (gnt_c != GNT_CLR),
    .busy       (clr_busy),
    .done       (clr_done),
    .start_ok_c (clr_start_ok_c),
    .fill_addr  (fill_addr),
    .fill_data  (fill_data)
  );

  // The host stays out during a fill, its done cycle, the cycle a fill is
  // accepted, and its own ack cycle so a held request cannot issue twice.
  assign host_ok_c = host.host_req && !host_ack_q && !clr_busy && !clr_done
                     && !clr_start_ok_c;

  always_comb begin
    gnt_c = GNT_NONE;
    if (disp_req) begin
      gnt_c = GNT_DISP;
    end else if (clr_busy) begin
      gnt_c = GNT_CLR;
    end else if (host_ok_c) begin
      gnt_c = GNT_HOST;
    end
  end

  always_comb begin
    cmd_c = '{we: 1'b0, addr: disp_addr, din: host.host_wdata};
    case (gnt_c)
      GNT_CLR:  cmd_c = '{we: 1'b1, addr: fill_addr, din: fill_data};
      GNT_HOST: cmd_c = '{we: host.host_we, addr: host.host_addr, din: host.host_wdata};
      default:  cmd_c = '{we: 1'b0, addr: disp_addr, din: host.host_wdata};
    endcase
  end

  // Write enable is forced low while reset is held.
  assign ram_addr = cmd_c.addr;
  assign ram_din  = cmd_c.din;
  assign ram_we   = cmd_c.we && reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_valid_q <= 1'b0;
      host_ack_q   <= 1'b0;
    end else begin
      disp_valid_q <= (gnt_c == GNT_DISP);
      host_ack_q   <= (gnt_c == GNT_HOST);
    end
  end

  assign disp_valid      = disp_valid_q;
  assign disp_data       = ram_dout;
  assign host.host_ack   = host_ack_q;
  assign host.host_rdata = ram_dout;

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Scoreboard bench for text_ram_arbiter with a behavioural 1024x8 registered-read RAM.
module tb_text_ram_arbiter;
  import text_ram_pkg::*;

  typedef struct {
    logic  is_rd;
    data_t data;
  } host_exp_t;

  logic  clk = 1'b0;
  logic  reset;
  logic  disp_req;
  addr_t disp_addr;
  data_t disp_data;
  logic  disp_valid;
  logic  clr_start;
  data_t clr_value;
  logic  clr_busy;
  logic  clr_done;
  addr_t ram_addr;
  data_t ram_din;
  logic  ram_we;
  data_t ram_dout;

  data_t mem [DEPTH];

  text_ram_arbiter_if hbus ();

  text_ram_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .disp_data  (disp_data),
    .disp_valid (disp_valid),
    .host       (hbus),
    .clr_start  (clr_start),
    .clr_value  (clr_value),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_we     (ram_we),
    .ram_dout   (ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  int        n_checks = 0;
  int        n_pass   = 0;
  data_t     disp_q[$];
  host_exp_t host_q[$];
  data_t     fill_val = 8'h00;
  int        wr_cnt   = 0;
  int        done_cnt = 0;
  logic      prev_busy = 1'b0;

  function automatic void check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endfunction

  // Monitor: pops the scoreboard on every output strobe and tracks fill writes.
  initial begin
    data_t     de;
    host_exp_t he;
    forever begin
      @(negedge clk);
      if (disp_valid) begin
        if (disp_q.size() == 0) check("disp_unexpected", 1, 0);
        else begin
          de = disp_q.pop_front();
          check("disp_data", disp_data, de);
        end
      end
      if (hbus.host_ack) begin
        if (host_q.size() == 0) check("host_ack_unexpected", 1, 0);
        else begin
          he = host_q.pop_front();
          if (he.is_rd) check("host_rdata", hbus.host_rdata, he.data);
        end
      end
      if (disp_req) check("disp_gnt", {ram_we, ram_addr}, {1'b0, disp_addr});
      if (clr_busy && !prev_busy) wr_cnt = 0;
      if (ram_we && clr_busy) begin
        check("fill_wr", {ram_addr, ram_din}, {wr_cnt[ADDR_W-1:0], fill_val});
        wr_cnt++;
      end
      if (clr_done) begin
        done_cnt++;
        check("done_total_writes", wr_cnt, DEPTH);
        check("done_busy_edge", {prev_busy, clr_busy}, 2'b10);
      end
      prev_busy = clr_busy;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic host_issue(input logic we, input addr_t a, input data_t d, input data_t exp);
    host_exp_t e;
    e.is_rd = !we;
    e.data  = exp;
    host_q.push_back(e);
    hbus.host_req   = 1'b1;
    hbus.host_we    = we;
    hbus.host_addr  = a;
    hbus.host_wdata = d;
  endtask

  // Waits for host_ack, then releases the request after the ack cycle.
  task automatic wait_ack(input string name, input int budget, output int cyc, output int since_done);
    logic got;
    got = 1'b0;
    cyc = 0;
    since_done = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cyc++;
      since_done++;
      if (clr_done) since_done = 0;
      if (hbus.host_ack) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check({name, "_ack_timeout"}, 0, 1);
    @(posedge clk);
    #1;
    hbus.host_req = 1'b0;
  endtask

  task automatic host_read(input addr_t a, input data_t exp);
    int c, s;
    host_issue(1'b0, a, 8'h00, exp);
    wait_ack("readback", 50, c, s);
  endtask

  initial begin
    int  cyc, sd, d0;
    logic re;

    reset = 1'b0;
    disp_req = 1'b0; disp_addr = '0;
    clr_start = 1'b0; clr_value = '0;
    hbus.host_req = 1'b1; hbus.host_we = 1'b1;
    hbus.host_addr = 10'h3FF; hbus.host_wdata = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_disp_valid", disp_valid, 0);
    check("rst_host_ack", hbus.host_ack, 0);
    check("rst_clr_busy", clr_busy, 0);
    check("rst_clr_done", clr_done, 0);
    check("rst_ram_we", ram_we, 0);
    hbus.host_req = 1'b0;
    hbus.host_we  = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    // Host write then readback with no display traffic.
    @(posedge clk); #1;
    host_issue(1'b1, 10'h005, 8'h37, 8'h00);
    @(negedge clk);
    check("t1_grant_cycle", {ram_we, ram_addr, ram_din}, {1'b1, 10'h005, 8'h37});
    wait_ack("t1_wr", 20, cyc, sd);
    check("t1_wr_ack_lat", cyc, 1);
    host_issue(1'b0, 10'h005, 8'h00, 8'h37);
    wait_ack("t1_rd", 20, cyc, sd);
    check("t1_rd_ack_lat", cyc, 2);
    host_issue(1'b1, 10'h010, 8'h5A, 8'h00);
    wait_ack("t1_wr2", 20, cyc, sd);

    // Display wins over a simultaneous host request.
    @(posedge clk); #1;
    disp_req = 1'b1; disp_addr = 10'h010; disp_q.push_back(8'h5A);
    host_issue(1'b0, 10'h010, 8'h00, 8'h5A);
    @(negedge clk);
    check("t2_disp_first", {ram_we, ram_addr}, {1'b0, 10'h010});
    @(posedge clk); #1;
    disp_addr = 10'h005; disp_q.push_back(8'h37);
    @(posedge clk); #1;
    disp_req = 1'b0;
    wait_ack("t2", 20, cyc, sd);
    check("t2_host_lat", cyc, 2);

    // Fill with 0x20 under periodic display fetches; a restart at write 500 is ignored.
    fill_val = 8'h20; clr_value = 8'h20; d0 = done_cnt; re = 1'b0;
    for (int k = 0; k < 1400; k++) begin
      @(posedge clk); #1;
      if (done_cnt != d0) break;
      clr_start = (k == 0);
      if (wr_cnt == 500 && !re) begin
        re = 1'b1; clr_start = 1'b1; clr_value = 8'h41;
      end
      disp_req = (k % 8 == 7);
      disp_addr = 10'h000;
      if (disp_req) disp_q.push_back(fill_val);
      if (k == 0) check("t3_busy_before", clr_busy, 0);
      if (k == 1) check("t3_busy_rise", clr_busy, 1);
    end
    disp_req = 1'b0; clr_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t3_done_once", done_cnt - d0, 1);
    host_read(10'h000, 8'h20);
    host_read(10'h1A5, 8'h20);
    host_read(10'h200, 8'h20);
    host_read(10'h3FF, 8'h20);

    // Host write issued mid-fill waits for the fill and then overrides it.
    fill_val = 8'h33; clr_value = 8'h33; d0 = done_cnt;
    clr_start = 1'b1;
    @(posedge clk); #1;
    clr_start = 1'b0;
    for (int k = 0; k < 2000 && wr_cnt < 100; k++) begin
      @(posedge clk); #1;
    end
    host_issue(1'b1, 10'h123, 8'h99, 8'h00);
    wait_ack("t5", 2000, cyc, sd);
    check("t5_done_before_ack", done_cnt - d0, 1);
    check("t5_gnt_after_done", sd >= 2, 1);
    host_read(10'h123, 8'h99);
    host_read(10'h124, 8'h33);

    // Reset mid-fill aborts without done or ack; refill restarts at address 0.
    fill_val = 8'h44; clr_value = 8'h44; d0 = done_cnt;
    clr_start = 1'b1;
    @(posedge clk); #1;
    clr_start = 1'b0;
    hbus.host_req = 1'b1; hbus.host_we = 1'b1;
    hbus.host_addr = 10'h300; hbus.host_wdata = 8'hEE;
    for (int k = 0; k < 2000 && wr_cnt < 300; k++) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    check("t6_busy_async", clr_busy, 0);
    check("t6_we_in_reset", ram_we, 0);
    hbus.host_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t6_ack_in_reset", hbus.host_ack, 0);
    check("t6_done_in_reset", clr_done, 0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t6_no_done", done_cnt - d0, 0);
    check("t6_idle_after", clr_busy, 0);

    // Restart with a simultaneous host read: the fill goes first.
    fill_val = 8'h55; clr_value = 8'h55; disp_addr = 10'h3C0;
    clr_start = 1'b1;
    host_issue(1'b0, 10'h000, 8'h00, 8'h55);
    @(negedge clk);
    check("t6_no_host_on_start", {ram_we, ram_addr}, {1'b0, 10'h3C0});
    @(posedge clk); #1;
    clr_start = 1'b0;
    wait_ack("t6", 2000, cyc, sd);
    check("t6_done_before_ack", done_cnt - d0, 1);
    check("t6_gnt_after_done", sd >= 2, 1);
    host_read(10'h2FF, 8'h55);
    host_read(10'h300, 8'h55);

    repeat (4) @(posedge clk);
    #1;
    check("disp_q_drained", disp_q.size(), 0);
    check("host_q_drained", host_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/text_ram_arbiter.md
Name: text_ram_arbiter

Overview:
Shares the single-port synchronous text RAM (1024 x 8, one-cycle read latency) between three requesters: video scan-out fetch, a host (CPU/UART loader) read/write port, and a built-in screen-clear sequencer. Sits between hvsync-driven character fetch logic and the text RAM. Display fetches are never delayed, so the raster stays glitch-free. Host accesses and screen fills use the remaining cycles.

Parameters:
ADDR_W, 10, RAM address width (32x32 cells); DEPTH = 2**ADDR_W
DATA_W, 8, RAM data width

Ports:
clk  in  1  pixel clock (clk25 domain)
reset  in  1  asynchronous, active-low reset
disp_req  in  1  display fetch request this cycle
disp_addr  in  ADDR_W  display cell address {row,col}
disp_data  out  DATA_W  fetched cell byte (= ram_dout)
disp_valid  out  1  disp_data valid (cycle after disp_req)
host_req  in  1  host access request, level, held until host_ack
host_we  in  1  1 = write, 0 = read
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_ack  out  1  one-cycle completion pulse
host_rdata  out  DATA_W  read data (= ram_dout), valid with host_ack on reads
clr_start  in  1  pulse: fill whole RAM with clr_value
clr_value  in  DATA_W  fill byte, sampled on accepted clr_start
clr_busy  out  1  fill in progress
clr_done  out  1  one-cycle pulse after last fill write
ram_addr  out  ADDR_W  to RAM
ram_din  out  DATA_W  to RAM
ram_we  out  1  to RAM
ram_dout  in  DATA_W  from RAM (registered read)

Behaviour:
- Reset (reset=0, async): disp_valid=0, host_ack=0, clr_busy=0, clr_done=0, fill counter=0, latched fill value=0, internal pending flags cleared. ram_we=0 while in reset.
- Fixed priority each cycle: DISP > CLR > HOST. The grant is combinational. ram_addr, ram_din and ram_we are muxed from the granted source in the same cycle.
- DISP grant: ram_addr=disp_addr, ram_we=0. disp_valid=1 in the next cycle. disp_data is ram_dout. Latency is exactly 1.
- CLR grant (clr_busy=1, no disp_req): ram_addr=fill counter, ram_din=latched clr_value, ram_we=1, counter increments.
- HOST grant (host_req=1, no disp_req, clr_busy=0, no host access in flight, host_ack=0 this cycle): drive host_addr, host_wdata and host_we.
  - host_ack pulses the next cycle. For reads, host_rdata is valid in that cycle.
  - The host may drop or change host_req in the ack cycle.
  - The arbiter never grants the host in a cycle where host_ack=1, so a held req cannot double-issue.
- No grant: ram_we=0, ram_addr=disp_addr (don't care).
- Host starvation: waits indefinitely while disp_req or clr_busy is held. This is acceptable because display fetch occurs at most 1 cycle in 8 and a fill is bounded.
- Clear sequencer:
  - clr_start with clr_busy=0: latch clr_value, counter:=0, clr_busy=1 from the next cycle.
  - clr_start while clr_busy=1: ignored (no restart, no relatch).
  - After the write to address DEPTH-1: counter wraps to 0, clr_busy falls the next cycle, and clr_done pulses in that same cycle.
  - Fill is stalled (not skipped) on cycles with disp_req. Total writes are exactly DEPTH.
- Simultaneous clr_start and host_req while idle: the fill starts. The host waits until clr_busy falls and is granted no earlier than the cycle after clr_done.
- Host access already granted when clr_start arrives: its ack still completes normally.
- Reset mid-fill or mid-host access: everything aborts immediately. No ack or done is issued, and partially filled RAM contents are left as-is.

Decomposition:
- Package text_ram_pkg:
  - ADDR_W and DATA_W constants.
  - Grant enum GNT_NONE, GNT_DISP, GNT_CLR, GNT_HOST.
- Sub-module clear_sequencer: counter, busy/done, value latch, and a stall input tied to "not granted".
- The arbiter top keeps the priority mux and the host in-flight/ack register.

Test Plan:
1. Host write addr 0x005 data 0x37 with no display traffic -> ram_we=1, ram_addr=0x005 in the grant cycle, host_ack the next cycle. A subsequent host read of 0x005 returns host_rdata=0x37 with host_ack.
2. disp_req and host_req asserted together at addr 0x010 -> display granted, disp_valid the next cycle. The host is granted the first cycle with disp_req=0 and acks once only, even though req is held.
3. clr_start with clr_value=0x20 and disp_req every 8th cycle -> exactly 1024 writes of 0x20 covering 0x000..0x3FF. Fill stalls on disp_req cycles. clr_done pulses once, coincident with clr_busy falling. A readback of random addresses returns 0x20.
4. clr_start again at write 500 with clr_value=0x41 -> ignored, all 1024 bytes still 0x20.
5. host_req issued at fill write 100 -> no host_ack until after clr_done. The host write then lands and overrides the fill at its address.
6. reset asserted at fill write 300 -> clr_busy=0 immediately (asynchronous). clr_done and host_ack stay 0. A new clr_start after release restarts from address 0.
